// File: rtl/vde_update_scheduler.sv
// Frame-synchronous palette/tilemap update scheduler: buffers bus writes in a FIFO and
// drains them one every two cycles inside the post-frame_start blanking window.
// Optional build macro VDE_UPD_IMMEDIATE_EN removes the window gating (drain whenever pending).
module vde_update_scheduler #(
    parameter int DEPTH        = 16,
    parameter int BLANK_CYCLES = 4096
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       frame_start_i,
    input  logic                       req_valid_i,
    input  logic                       req_kind_i,
    input  logic [31:0]                req_data_i,
    output logic                       req_ready_o,
    output logic [31:0]                update_wvalue_o,
    output logic                       update_color_upd_o,
    output logic                       update_map_upd_o,
    output logic [$clog2(DEPTH):0]     pending_o,
    output logic                       window_open_o,
    output logic                       overflow_o,
    input  logic                       clear_overflow_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic        kind;
        logic [31:0] data;
    } entry_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    state_t        state_nxt;
    logic          push;
    logic          pop;
    logic          drop;
    entry_t        head;

    assign pending_o   = count;
    assign req_ready_o = (count != CW'(DEPTH));
    assign push        = req_valid_i & req_ready_o;
    assign drop        = req_valid_i & ~req_ready_o;
    assign pop         = (state == ISSUE);
    assign head        = mem[rd_ptr];

    // Storage has no reset: a reset flush only needs the pointers and count cleared.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= '{kind: req_kind_i, data: req_data_i};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end else if (clear_overflow_i) begin
            overflow_o <= 1'b0;
        end
    end

`ifdef VDE_UPD_IMMEDIATE_EN
    logic unused_frame_start;
    assign unused_frame_start = frame_start_i;
    assign window_open_o      = 1'b1;
`else
    localparam int WW = $clog2(BLANK_CYCLES + 1);

    logic [WW-1:0] win_cnt;

    // window_open_o tracks the counter's next value so it equals (win_cnt != 0) every cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            win_cnt       <= '0;
            window_open_o <= 1'b0;
        end else begin
            if (frame_start_i) begin
                win_cnt <= WW'(BLANK_CYCLES);
            end else if (win_cnt != '0) begin
                win_cnt <= win_cnt - 1'b1;
            end
            window_open_o <= frame_start_i | (win_cnt > WW'(1));
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ISSUE always falls back to IDLE, which spaces strobes at least two cycles apart.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (window_open_o && (count != '0)) state_nxt = ISSUE;
            ISSUE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            update_wvalue_o    <= '0;
            update_color_upd_o <= 1'b0;
            update_map_upd_o   <= 1'b0;
        end else begin
            update_color_upd_o <= pop & ~head.kind;
            update_map_upd_o   <= pop &  head.kind;
            if (pop) begin
                update_wvalue_o <= head.data;
            end
        end
    end

endmodule

// File: tb/tb_vde_update_scheduler.sv
// Scoreboard bench for vde_update_scheduler: a queue-based interface model predicts
// accepted entries, occupancy, readiness and overflow; monitors check every strobe.
module tb_vde_update_scheduler;
    localparam int DEPTH = 16;
    localparam int BLANK = 4096;
    localparam int SBLANK = 4;

    logic clk = 1'b0;
    logic rstn;
    logic fs, rv, rk, clr;
    logic [31:0] rd;
    logic [31:0] upd_w;
    logic c_upd, m_upd, ready, win, ovf;
    logic [4:0] pend;

    logic s_fs, s_rv, s_rk;
    logic [31:0] s_rd;
    logic [31:0] s_w;
    logic s_c, s_m, s_ready, s_win, s_ovf;
    logic [4:0] s_pend;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    vde_update_scheduler #(.DEPTH(DEPTH), .BLANK_CYCLES(BLANK)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .frame_start_i(fs), .req_valid_i(rv),
        .req_kind_i(rk), .req_data_i(rd), .req_ready_o(ready), .update_wvalue_o(upd_w),
        .update_color_upd_o(c_upd), .update_map_upd_o(m_upd), .pending_o(pend),
        .window_open_o(win), .overflow_o(ovf), .clear_overflow_i(clr)
    );

    vde_update_scheduler #(.DEPTH(DEPTH), .BLANK_CYCLES(SBLANK)) u_small (
        .clk_i(clk), .rstn_i(rstn), .frame_start_i(s_fs), .req_valid_i(s_rv),
        .req_kind_i(s_rk), .req_data_i(s_rd), .req_ready_o(s_ready), .update_wvalue_o(s_w),
        .update_color_upd_o(s_c), .update_map_upd_o(s_m), .pending_o(s_pend),
        .window_open_o(s_win), .overflow_o(s_ovf), .clear_overflow_i(1'b0)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model for the main instance ----------------
    logic [32:0] q[$];
    int  mp = 0;
    bit  exp_ovf = 1'b0;
    bit  push_now = 1'b0;
    int  last_fs = -100000;
    int  last_push = -100000;
    int  last_strobe = -100000;
    int  strobes = 0;
    int  st_cyc[$];

    always @(posedge clk) begin
        cyc++;
        push_now = rstn && rv && (mp != DEPTH);
        if (push_now) begin
            q.push_back({rk, rd});
            last_push = cyc;
        end
        if (rstn && rv && (mp == DEPTH)) exp_ovf = 1'b1;
        else if (rstn && clr)           exp_ovf = 1'b0;
        if (rstn && fs) last_fs = cyc;
    end

    always @(negedge clk) begin
        logic [32:0] e;
        bit strobe;
        if (!rstn) begin
            q.delete();
            mp = 0;
            exp_ovf = 1'b0;
            push_now = 1'b0;
            last_fs = -100000;
            chk("reset_pending", pend, 0);
            chk("reset_strobes", {c_upd, m_upd}, 0);
        end else begin
            strobe = c_upd | m_upd;
            if (strobe) begin
                chk("strobe_exclusive", {c_upd, m_upd} != 2'b11, 1);
                chk("strobe_spacing", (cyc - last_strobe) >= 2, 1);
`ifndef VDE_UPD_IMMEDIATE_EN
                chk("strobe_in_window", (cyc - last_fs) <= BLANK + 1, 1);
`endif
                if (q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("strobe_kind", {c_upd, m_upd}, e[32] ? 2'b01 : 2'b10);
                    chk("strobe_data", upd_w, e[31:0]);
                end
                last_strobe = cyc;
                strobes++;
                st_cyc.push_back(cyc);
            end
            mp = mp + int'(push_now) - int'(strobe);
            push_now = 1'b0;
            chk("pending", pend, mp);
            chk("ready", ready, mp != DEPTH);
            chk("overflow", ovf, exp_ovf);
        end
    end

    // ---------------- small-window instance monitor ----------------
    logic [32:0] s_q[$];
    int s_strobes = 0;

    always @(posedge clk) begin
        if (rstn && s_rv) s_q.push_back({s_rk, s_rd});
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (!rstn) begin
            s_q.delete();
        end else if (s_c | s_m) begin
            s_strobes++;
            if (s_q.size() == 0) begin
                chk("small_unexpected_strobe", 1, 0);
            end else begin
                e = s_q.pop_front();
                chk("small_kind", {s_c, s_m}, e[32] ? 2'b01 : 2'b10);
                chk("small_data", s_w, e[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic k, input logic [31:0] d);
        rv = 1'b1; rk = k; rd = d;
        tick();
        rv = 1'b0;
    endtask

    task automatic frame();
        fs = 1'b1;
        tick();
        fs = 1'b0;
    endtask

    task automatic wait_closed();
        repeat (BLANK + 4) tick();
    endtask

    initial begin
        int base;
        rstn = 1'b0; fs = 1'b0; rv = 1'b0; rk = 1'b0; rd = '0; clr = 1'b0;
        s_fs = 1'b0; s_rv = 1'b0; s_rk = 1'b0; s_rd = '0;
        repeat (3) tick();
        chk("rst_pending", pend, 0);
        chk("rst_ready", ready, 1);
        chk("rst_strobes", {c_upd, m_upd}, 0);
        chk("rst_wvalue", upd_w, 0);
        chk("rst_overflow", ovf, 0);
`ifndef VDE_UPD_IMMEDIATE_EN
        chk("rst_window", win, 0);
`endif
        rstn = 1'b1;
        tick();

`ifndef VDE_UPD_IMMEDIATE_EN
        // Three updates held until a frame opens the window.
        push(1'b0, 32'h05FF_0000);
        push(1'b1, 32'h0000_4201);
        push(1'b0, 32'h0700_0000);
        chk("t1_pending3", pend, 3);
        base = strobes;
        repeat (10000) tick();
        chk("t1_no_strobe_closed", strobes - base, 0);
        st_cyc.delete();
        frame();
        repeat (20) tick();
        chk("t1_strobe_count", strobes - base, 3);
        if (st_cyc.size() == 3) begin
            chk("t1_spacing_a", st_cyc[1] - st_cyc[0], 2);
            chk("t1_spacing_b", st_cyc[2] - st_cyc[1], 2);
        end else begin
            chk("t1_strobe_list", st_cyc.size(), 3);
        end
        chk("t1_drained", pend, 0);

        // Short window: 5 queued, 2 drained per frame.
        for (int i = 0; i < 5; i++) begin
            s_rv = 1'b1; s_rk = i[0]; s_rd = 32'h5000_0000 + i;
            tick();
        end
        s_rv = 1'b0;
        chk("small_pending5", s_pend, 5);
        s_fs = 1'b1; tick(); s_fs = 1'b0;
        repeat (15) tick();
        chk("small_strobes_frame1", s_strobes, 2);
        chk("small_pending_frame1", s_pend, 3);
        chk("small_window_closed", s_win, 0);
        s_fs = 1'b1; tick(); s_fs = 1'b0;
        repeat (15) tick();
        chk("small_strobes_frame2", s_strobes, 4);
        chk("small_pending_frame2", s_pend, 1);
        chk("small_ready", s_ready, 1);
        chk("small_no_overflow", s_ovf, 0);

        // Overflow: 17 pushes into a 16-entry FIFO with the window closed.
        wait_closed();
        for (int i = 0; i <= DEPTH; i++) push(i[0], 32'hA000_0000 + i);
        chk("ovf_ready_low", ready, 0);
        chk("ovf_pending_full", pend, DEPTH);
        chk("ovf_set", ovf, 1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovf_cleared", ovf, 0);
        frame();
        repeat (50) tick();
        chk("ovf_drained", pend, 0);

        // Push coinciding with the pop at DEPTH-1.
        wait_closed();
        for (int i = 0; i < DEPTH - 1; i++) push(i[1], 32'hB000_0000 + i);
        chk("pp_pending15", pend, DEPTH - 1);
        fs = 1'b1; tick(); fs = 1'b0;
        tick();
        rv = 1'b1; rk = 1'b1; rd = 32'hC0FF_EE00;
        tick();
        rv = 1'b0;
        chk("pp_pop_strobe", c_upd | m_upd, 1);
        chk("pp_pending_held", pend, DEPTH - 1);
        repeat (60) tick();
        chk("pp_drained", pend, 0);
        wait_closed();
`else
        // Immediate mode: an entry strobes two cycles after its push.
        push(1'b1, 32'h1234_5678);
        repeat (4) tick();
        chk("imm_latency", st_cyc[st_cyc.size()-1] - last_push, 2);
        chk("imm_window", win, 1);
`endif

        // Randomized traffic, then a final drain.
        for (int i = 0; i < 800; i++) begin
            rv  = ($urandom_range(0, 1) == 1);
            rk  = ($urandom_range(0, 1) == 1);
            rd  = $urandom;
            fs  = ($urandom_range(0, 63) == 0);
            clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        rv = 1'b0; fs = 1'b0; clr = 1'b0;
        frame();
        repeat (60) tick();
        chk("rand_drained", pend, 0);
        chk("rand_model_empty", q.size(), 0);

        // Reset in the middle of a drain.
        for (int i = 0; i <= DEPTH; i++) push(i[0], 32'hD000_0000 + i);
        frame();
        repeat (6) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("rst_mid_pending", pend, 0);
        chk("rst_mid_overflow", ovf, 0);
        base = strobes;
        repeat (100) tick();
        chk("rst_mid_no_strobes", strobes - base, 0);

`ifdef VDE_UPD_IMMEDIATE_EN
        push(1'b0, 32'h0BAD_F00D);
        repeat (4) tick();
        chk("imm_after_reset", st_cyc[st_cyc.size()-1] - last_push, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
